// File: rtl/pool_window_gen_pkg.sv
// ----------------------------------------------------------------------------
// pool_window_gen_pkg
// Shared definitions for the raster-to-window reorder stage:
//   - state_e   : controller states of pool_window_gen
//   - POOL_*    : pool_type encodings shared with pooling_unit
//   - wrap_add  : (a + b) mod k for a, b < k, by conditional subtract
// ----------------------------------------------------------------------------
package pool_window_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_EMIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_NEXT  = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  localparam logic [1:0] POOL_MAX = 2'd0;
  localparam logic [1:0] POOL_AVG = 2'd1;
  localparam logic [1:0] POOL_MIN = 2'd2;

  // Circular line-buffer row index; both operands are already below k.
  function automatic logic [7:0] wrap_add(input logic [7:0] a,
                                          input logic [7:0] b,
                                          input logic [7:0] k);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, k}) s = s - {1'b0, k};
    return 8'(s);
  endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// ----------------------------------------------------------------------------
// pool_line_buffer
// MAX_POOL_SIZE x MAX_WIDTH element store holding the rows of the current
// pooling band. One synchronous write port, one asynchronous read port, so it
// maps onto distributed RAM.
// Ports:
//   clk                     clock
//   i_we, i_wrow, i_wcol    write enable and address
//   i_wdata                 write data
//   i_rrow, i_rcol          read address
//   o_rdata                 read data (combinational)
// ----------------------------------------------------------------------------
module pool_line_buffer #(
  parameter int DATA_WIDTH    = 16,
  parameter int MAX_POOL_SIZE = 3,
  parameter int MAX_WIDTH     = 256,
  parameter int RAW           = 2,
  parameter int CAW           = 8
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [RAW-1:0]        i_wrow,
  input  logic [CAW-1:0]        i_wcol,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [RAW-1:0]        i_rrow,
  input  logic [CAW-1:0]        i_rcol,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [MAX_POOL_SIZE][MAX_WIDTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_wrow][i_wcol] <= i_wdata;
  end

  assign o_rdata = r_mem[i_rrow][i_rcol];

endmodule

// File: rtl/pool_window_gen.sv
// ----------------------------------------------------------------------------
// pool_window_gen
// Reorders a channel-major, row-major raster stream into pool_size x pool_size
// windows (row-major inside a window; windows by output row, output column,
// channel) for pooling_unit. pool_size rows are kept in a circular line buffer
// so overlapping windows need no re-fetch.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start, clear           job start (IDLE only), synchronous abort
//   busy, done, cfg_err    job status, end-of-job pulse, sticky config error
//   pool_size, stride      window edge K, step S
//   input_height/width     H, W
//   num_channels           C
//   in_data/valid/ready    raster input stream
//   out_data/valid/ready   window output stream
//   out_win_last           last element of a window
//   out_plane_last         last element of the last window of a channel
// ----------------------------------------------------------------------------
module pool_window_gen
  import pool_window_gen_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int MAX_POOL_SIZE = 3,
  parameter int MAX_WIDTH     = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  clear,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err,
  input  logic [7:0]            pool_size,
  input  logic [7:0]            stride,
  input  logic [15:0]           input_height,
  input  logic [15:0]           input_width,
  input  logic [15:0]           num_channels,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_win_last,
  output logic                  out_plane_last
);

  localparam int RAW = (MAX_POOL_SIZE > 1) ? $clog2(MAX_POOL_SIZE) : 1;
  localparam int CAW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;

  state_e r_state, w_state_nxt;

  logic [7:0]  r_k, r_s, r_top, r_need, r_loaded, r_wr, r_wc;
  logic [15:0] r_h, r_w, r_c, r_oh, r_ow, r_rem;
  logic [15:0] r_col, r_cbase, r_ocol, r_orow, r_ch;
  logic        r_calc, r_cfg_err;

  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_valid, r_win_last, r_plane_last;

  logic w_cfg_ok, w_in_acc, w_col_wrap, w_fill_done, w_drain_done;
  logic w_load, w_last_wc, w_last_wr, w_win_end, w_row_end, w_plane_end;
  logic [7:0]  w_wrow, w_rrow;
  logic [15:0] w_rcol;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic w_unused;

  assign w_cfg_ok = (pool_size != 8'd0) && ({24'd0, pool_size} <= MAX_POOL_SIZE) &&
                    (stride != 8'd0) && (stride <= pool_size) &&
                    ({8'd0, pool_size} <= input_height) &&
                    ({8'd0, pool_size} <= input_width) &&
                    ({16'd0, input_width} <= MAX_WIDTH) &&
                    (num_channels != 16'd0);

  // clear wins over the input handshake, so in_ready drops with it.
  assign in_ready = ((r_state == ST_FILL) || (r_state == ST_DRAIN)) && !clear;
  assign w_in_acc = in_valid && in_ready;

  assign w_col_wrap   = (r_col == r_w - 16'd1);
  assign w_fill_done  = (r_state == ST_FILL) && w_in_acc && w_col_wrap &&
                        (r_loaded + 8'd1 == r_need);
  assign w_drain_done = (r_state == ST_DRAIN) && w_in_acc && w_col_wrap &&
                        ({8'd0, r_loaded + 8'd1} == r_rem);

  // Output register is refilled on the same edge it is drained: no bubbles.
  assign w_load      = (r_state == ST_EMIT) && (!r_out_valid || out_ready) && !clear;
  assign w_last_wc   = (r_wc == r_k - 8'd1);
  assign w_last_wr   = (r_wr == r_k - 8'd1);
  assign w_win_end   = w_last_wc && w_last_wr;
  assign w_row_end   = w_win_end && (r_ocol == r_ow - 16'd1);
  assign w_plane_end = w_row_end && (r_orow == r_oh - 16'd1);

  // New rows land behind the rows kept from the previous band.
  assign w_wrow = wrap_add(r_top, r_k - r_need + r_loaded, r_k);
  assign w_rrow = wrap_add(r_top, r_wr, r_k);
  assign w_rcol = r_cbase + {8'd0, r_wc};

  assign w_unused = ^{w_wrow[7:RAW], w_rrow[7:RAW], r_col[15:CAW], w_rcol[15:CAW]};

  pool_line_buffer #(
    .DATA_WIDTH    (DATA_WIDTH),
    .MAX_POOL_SIZE (MAX_POOL_SIZE),
    .MAX_WIDTH     (MAX_WIDTH),
    .RAW           (RAW),
    .CAW           (CAW)
  ) u_lbuf (
    .clk     (clk),
    .i_we    ((r_state == ST_FILL) && w_in_acc),
    .i_wrow  (w_wrow[RAW-1:0]),
    .i_wcol  (r_col[CAW-1:0]),
    .i_wdata (in_data),
    .i_rrow  (w_rrow[RAW-1:0]),
    .i_rcol  (w_rcol[CAW-1:0]),
    .o_rdata (w_rdata)
  );

  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (start) w_state_nxt = w_cfg_ok ? ST_FILL : ST_DONE;
        ST_FILL:  if (w_fill_done) w_state_nxt = ST_EMIT;
        ST_EMIT: begin
          if (w_load && w_row_end) begin
            if (r_orow != r_oh - 16'd1) w_state_nxt = ST_FILL;
            else if (r_rem != 16'd0)    w_state_nxt = ST_DRAIN;
            else                        w_state_nxt = ST_NEXT;
          end
        end
        ST_DRAIN: if (w_drain_done) w_state_nxt = ST_NEXT;
        // The job only ends once the final element has left the output register.
        ST_NEXT: begin
          if (r_ch + 16'd1 != r_c)              w_state_nxt = ST_FILL;
          else if (!r_out_valid || out_ready)   w_state_nxt = ST_DONE;
        end
        ST_DONE:  w_state_nxt = ST_IDLE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k <= '0; r_s <= '0; r_h <= '0; r_w <= '0; r_c <= '0;
      r_oh <= '0; r_ow <= '0; r_rem <= '0; r_calc <= 1'b0; r_cfg_err <= 1'b0;
      r_top <= '0; r_need <= '0; r_loaded <= '0; r_wr <= '0; r_wc <= '0;
      r_col <= '0; r_cbase <= '0; r_ocol <= '0; r_orow <= '0; r_ch <= '0;
    end else begin
      r_calc <= 1'b0;
      // Derived sizes settle in the first FILL cycle, long before EMIT needs them.
      if (r_calc) begin
        r_oh  <= (r_h - {8'd0, r_k}) / {8'd0, r_s} + 16'd1;
        r_ow  <= (r_w - {8'd0, r_k}) / {8'd0, r_s} + 16'd1;
        r_rem <= (r_h - {8'd0, r_k}) % {8'd0, r_s};
      end
      if (!clear) begin
        case (r_state)
          ST_IDLE: if (start) begin
            r_k <= pool_size; r_s <= stride; r_h <= input_height;
            r_w <= input_width; r_c <= num_channels;
            r_cfg_err <= !w_cfg_ok; r_calc <= 1'b1;
            r_top <= '0; r_need <= pool_size; r_loaded <= '0; r_col <= '0;
            r_wr <= '0; r_wc <= '0; r_cbase <= '0; r_ocol <= '0; r_orow <= '0;
            r_ch <= '0;
          end
          ST_FILL, ST_DRAIN: if (w_in_acc) begin
            if (w_col_wrap) begin
              r_col    <= '0;
              r_loaded <= r_loaded + 8'd1;
            end else begin
              r_col <= r_col + 16'd1;
            end
          end
          ST_EMIT: if (w_load) begin
            if (!w_last_wc) begin
              r_wc <= r_wc + 8'd1;
            end else begin
              r_wc <= '0;
              if (!w_last_wr) begin
                r_wr <= r_wr + 8'd1;
              end else begin
                r_wr <= '0;
                if (!w_row_end) begin
                  r_ocol  <= r_ocol + 16'd1;
                  r_cbase <= r_cbase + {8'd0, r_s};
                end else begin
                  // Slide the band down by S rows; only S fresh rows are fetched.
                  r_ocol   <= '0;
                  r_cbase  <= '0;
                  r_orow   <= r_orow + 16'd1;
                  r_top    <= wrap_add(r_top, r_s, r_k);
                  r_need   <= r_s;
                  r_loaded <= '0;
                  r_col    <= '0;
                end
              end
            end
          end
          ST_NEXT: if (w_state_nxt == ST_FILL) begin
            r_ch <= r_ch + 16'd1;
            r_top <= '0; r_need <= r_k; r_loaded <= '0; r_col <= '0;
            r_orow <= '0; r_ocol <= '0; r_cbase <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data <= '0; r_out_valid <= 1'b0; r_win_last <= 1'b0; r_plane_last <= 1'b0;
    end else if (clear) begin
      r_out_valid <= 1'b0; r_win_last <= 1'b0; r_plane_last <= 1'b0;
    end else if (w_load) begin
      r_out_data   <= w_rdata;
      r_out_valid  <= 1'b1;
      r_win_last   <= w_win_end;
      r_plane_last <= w_plane_end;
    end else if (out_ready) begin
      r_out_valid <= 1'b0; r_win_last <= 1'b0; r_plane_last <= 1'b0;
    end
  end

  assign busy           = (r_state == ST_FILL) || (r_state == ST_EMIT) ||
                          (r_state == ST_DRAIN) || (r_state == ST_NEXT);
  assign done           = (r_state == ST_DONE);
  assign cfg_err        = r_cfg_err;
  assign out_data       = r_out_data;
  assign out_valid      = r_out_valid;
  assign out_win_last   = r_win_last;
  assign out_plane_last = r_plane_last;

endmodule

// File: tb/tb_pool_window_gen.sv
module tb_pool_window_gen;

  logic        clk;
  logic        rst_n, start, clear;
  logic        busy, done, cfg_err;
  logic [7:0]  pool_size, stride;
  logic [15:0] input_height, input_width, num_channels;
  logic [15:0] in_data;
  logic        in_valid, in_ready;
  logic [15:0] out_data;
  logic        out_valid, out_ready, out_win_last, out_plane_last;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pool_window_gen #(.DATA_WIDTH(16), .MAX_POOL_SIZE(3), .MAX_WIDTH(256)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
    .busy(busy), .done(done), .cfg_err(cfg_err),
    .pool_size(pool_size), .stride(stride),
    .input_height(input_height), .input_width(input_width), .num_channels(num_channels),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_win_last(out_win_last), .out_plane_last(out_plane_last)
  );

  int n_vec = 0;
  int n_miss = 0;
  int got_d[$];
  bit got_wl[$];
  bit got_pl[$];
  int exp_q[$];
  int n_in, n_done, n_stall_bad, rdy_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [7:0] k, input logic [7:0] s,
                          input logic [15:0] h, input logic [15:0] w, input logic [15:0] c);
    @(negedge clk);
    pool_size = k; stride = s; input_height = h; input_width = w; num_channels = c;
    in_valid = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Drives the raster 0,1,2,... and records every output handshake until done
  // (plus a few idle cycles), or until the abort point when abort_at > 0.
  task automatic run_job(input bit bp, input int abort_at, input int budget);
    int idx; int post;
    logic pv, pr, pwl, ppl;
    logic [15:0] pd;
    idx = 0; post = 0; pv = 1'b0; pr = 1'b1; pd = '0; pwl = 1'b0; ppl = 1'b0;
    got_d.delete(); got_wl.delete(); got_pl.delete();
    n_done = 0; n_stall_bad = 0; rdy_seen = 0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      in_valid  = 1'b1;
      in_data   = idx[15:0];
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      clear     = (abort_at > 0) && (got_d.size() == abort_at);
      #1;
      if (pv && !pr && (out_valid !== 1'b1 || out_data !== pd ||
                        out_win_last !== pwl || out_plane_last !== ppl))
        n_stall_bad++;
      pv = out_valid; pr = out_ready; pd = out_data; pwl = out_win_last; ppl = out_plane_last;
      if (in_ready) rdy_seen++;
      if (in_valid && in_ready) idx++;
      if (out_valid && out_ready) begin
        got_d.push_back(int'(out_data));
        got_wl.push_back(out_win_last);
        got_pl.push_back(out_plane_last);
      end
      if (done) n_done++;
      if (clear) begin
        @(negedge clk);
        clear = 1'b0; in_valid = 1'b0;
        break;
      end
      if (n_done > 0) post++;
      if (post > 3) break;
      @(negedge clk);
    end
    n_in = idx;
    in_valid = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic check_stream(input string tag, input int kk, input int pl_a, input int pl_b);
    check({tag, "_count"}, 32'(got_d.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_d.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i), 32'(got_d[i]), 32'(exp_q[i]));
      check($sformatf("%s_winlast%0d", tag, i), 32'(got_wl[i]),
            32'((i % (kk * kk)) == (kk * kk - 1)));
      check($sformatf("%s_planelast%0d", tag, i), 32'(got_pl[i]),
            32'((i == pl_a) || (i == pl_b)));
    end
  endtask

  task automatic case1_expect();
    exp_q = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; clear = 1'b0;
    pool_size = '0; stride = '0; input_height = '0; input_width = '0; num_channels = '0;
    in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_cfg_err", 32'(cfg_err), 32'(0));
    check("rst_in_ready", 32'(in_ready), 32'(0));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_out_data", 32'(out_data), 32'(0));
    check("rst_win_last", 32'(out_win_last), 32'(0));
    check("rst_plane_last", 32'(out_plane_last), 32'(0));
    rst_n = 1'b1;

    // Case 1: K=2 S=2 on 4x4
    do_start(8'd2, 8'd2, 16'd4, 16'd4, 16'd1);
    check("c1_busy_after_start", 32'(busy), 32'(1));
    run_job(1'b0, 0, 500);
    check("c1_done_pulses", 32'(n_done), 32'(1));
    check("c1_inputs", 32'(n_in), 32'(16));
    case1_expect();
    check_stream("c1", 2, 15, -1);

    // Case 2: K=3 S=1 on 4x4, overlapping windows
    do_start(8'd3, 8'd1, 16'd4, 16'd4, 16'd1);
    run_job(1'b0, 0, 500);
    check("c2_done_pulses", 32'(n_done), 32'(1));
    check("c2_inputs", 32'(n_in), 32'(16));
    exp_q = '{0, 1, 2, 4, 5, 6, 8, 9, 10,
              1, 2, 3, 5, 6, 7, 9, 10, 11,
              4, 5, 6, 8, 9, 10, 12, 13, 14,
              5, 6, 7, 9, 10, 11, 13, 14, 15};
    check_stream("c2", 3, 35, -1);

    // Case 3: 2 channels, 5x5, K=2 S=2, column 4 and row 4 dropped
    do_start(8'd2, 8'd2, 16'd5, 16'd5, 16'd2);
    run_job(1'b0, 0, 800);
    check("c3_done_pulses", 32'(n_done), 32'(1));
    check("c3_inputs", 32'(n_in), 32'(50));
    exp_q = '{0, 1, 5, 6, 2, 3, 7, 8, 10, 11, 15, 16, 12, 13, 17, 18,
              25, 26, 30, 31, 27, 28, 32, 33, 35, 36, 40, 41, 37, 38, 42, 43};
    check_stream("c3", 2, 15, 31);

    // Case 1 under random backpressure
    do_start(8'd2, 8'd2, 16'd4, 16'd4, 16'd1);
    run_job(1'b1, 0, 1500);
    check("bp_done_pulses", 32'(n_done), 32'(1));
    check("bp_stall_hold", 32'(n_stall_bad), 32'(0));
    case1_expect();
    check_stream("bp", 2, 15, -1);

    // Illegal: K above MAX_POOL_SIZE
    do_start(8'd4, 8'd1, 16'd8, 16'd8, 16'd1);
    run_job(1'b0, 0, 50);
    check("ill_k_done", 32'(n_done), 32'(1));
    check("ill_k_cfg_err", 32'(cfg_err), 32'(1));
    check("ill_k_in_ready", 32'(rdy_seen), 32'(0));
    check("ill_k_outputs", 32'(got_d.size()), 32'(0));

    // Illegal: S > K
    do_start(8'd2, 8'd3, 16'd4, 16'd4, 16'd1);
    run_job(1'b0, 0, 50);
    check("ill_s_done", 32'(n_done), 32'(1));
    check("ill_s_cfg_err", 32'(cfg_err), 32'(1));
    check("ill_s_in_ready", 32'(rdy_seen), 32'(0));
    check("ill_s_inputs", 32'(n_in), 32'(0));

    // Legal start clears cfg_err
    do_start(8'd2, 8'd2, 16'd4, 16'd4, 16'd1);
    check("legal_clears_cfg_err", 32'(cfg_err), 32'(0));
    run_job(1'b0, 0, 500);
    check("legal_done", 32'(n_done), 32'(1));
    case1_expect();
    check_stream("legal", 2, 15, -1);

    // Clear in the middle of the first window
    do_start(8'd2, 8'd2, 16'd4, 16'd4, 16'd1);
    run_job(1'b0, 2, 500);
    check("clr_out_valid", 32'(out_valid), 32'(0));
    check("clr_busy", 32'(busy), 32'(0));
    check("clr_in_ready", 32'(in_ready), 32'(0));
    for (int i = 0; i < 5; i++) begin
      if (done) n_done++;
      @(negedge clk);
    end
    check("clr_no_done", 32'(n_done), 32'(0));
    do_start(8'd2, 8'd2, 16'd4, 16'd4, 16'd1);
    run_job(1'b0, 0, 500);
    check("rerun_done", 32'(n_done), 32'(1));
    case1_expect();
    check_stream("rerun", 2, 15, -1);

    // Asynchronous reset while an element is held under backpressure
    do_start(8'd2, 8'd2, 16'd4, 16'd4, 16'd1);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 14; i++) begin
      in_data = 16'(i);
      @(negedge clk);
    end
    check("ar_pre_valid", 32'(out_valid), 32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_out_valid", 32'(out_valid), 32'(0));
    check("ar_busy", 32'(busy), 32'(0));
    check("ar_in_ready", 32'(in_ready), 32'(0));
    check("ar_out_data", 32'(out_data), 32'(0));
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/pool_window_gen.md
Name: pool_window_gen

Overview:
- Raster-to-window reorder stage that sits directly upstream of pooling_unit.
- Accepts a feature map as a raster stream: channel-major, then row-major, one element per handshake.
- Re-emits it as a stream of pool_size×pool_size windows. Each window is row-major; windows are ordered by output row, then output column, then channel. This matches pooling_unit's LOAD_WINDOW fill order.
- Holds pool_size input rows in a circular line buffer so that overlapping windows (stride < pool_size) need no re-fetch.

Parameters:
- DATA_WIDTH, 16, element width.
- MAX_POOL_SIZE, 3, maximum window edge; sets the number of line-buffer rows.
- MAX_WIDTH, 256, maximum input_width; sets the line-buffer depth per row.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a job; sampled only in IDLE.
- clear  in  1  synchronous abort to IDLE.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at job end.
- cfg_err  out  1  sticky illegal-config flag; cleared by the next start.
- pool_size  in  8  window edge K.
- stride  in  8  step S.
- input_height  in  16  H.
- input_width  in  16  W.
- num_channels  in  16  C.
- in_data  in  DATA_WIDTH  raster element.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept in_data.
- out_data  out  DATA_WIDTH  window element.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream can accept out_data.
- out_win_last  out  1  qualifies the last (K×K-th) element of a window.
- out_plane_last  out  1  qualifies the last element of the last window of a channel.

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0; state IDLE; counters 0; line-buffer contents undefined.
- Config capture: on start in IDLE, K, S, H, W and C are registered and held for the whole job.
- Legal config: 1≤K≤MAX_POOL_SIZE, 1≤S≤K, K≤H, K≤W≤MAX_WIDTH, C≥1.
  - If illegal: cfg_err=1, go to DONE (done pulses), no data consumed.
- Derived sizes:
  - OH=(H−K)/S+1 and OW=(W−K)/S+1, using unsigned integer division.
  - Computed once, in the cycle after start.
- States:
  - IDLE: start → FILL with need=K, top=0.
  - FILL:
    - in_ready=1. Each accepted element is written to buf[(top+r) mod K][col].
    - col wraps at W−1. On wrap, loaded is incremented.
    - When loaded==need → EMIT.
  - EMIT:
    - in_ready=0. Emits window (or, oc) as element (wr,wc) = buf[(top+wr) mod K][oc·S+wc].
    - wc runs fastest, then wr. Each element advances on out_valid&&out_ready.
    - At the end of a window, oc is incremented. At oc==OW−1 the output row is complete:
      - or<OH−1: top=(top+S) mod K, need=S, loaded=0 → FILL.
      - or==OH−1 and leftover rows R=H−K−(OH−1)·S > 0 → DRAIN.
      - or==OH−1 and R==0 → NEXT.
  - DRAIN: in_ready=1. Accepts and discards R·W elements → NEXT.
  - NEXT:
    - ch++. If ch==C → DONE.
    - Otherwise top=0, need=K, or=oc=0 → FILL.
  - DONE: done=1 for one cycle, busy=0 → IDLE.
- Remainder handling:
  - Columns ≥ OW·S... beyond the last window that fully fits in a row are stored but never emitted.
  - Rows beyond the last full window are drained. This keeps the next channel aligned.
- Output register and handshake:
  - out_data, out_valid, out_win_last and out_plane_last are registers.
  - While out_valid=1 and out_ready=0, all four hold stable.
  - The next element is loaded in the same cycle as an accepting handshake, so there are no bubbles inside a window.
  - out_valid never drops mid-window unless clear is asserted.
- Input handshake: an element transfers only when in_valid&&in_ready. in_ready is deasserted in EMIT and IDLE.
- Arithmetic:
  - The column index oc·S+wc is ≤ W−1 by construction. Counters are 16 bits.
  - Circular row index: (top+x) mod K, computed by conditional subtract (top,x<K).
- Simultaneous events:
  - clear has priority over start and over any handshake.
  - start is ignored outside IDLE.
- Clear: from any state, in the next cycle go to IDLE with out_valid=0, in_ready=0, busy=0, no done pulse. Partially received data is discarded.
- Reset mid-operation: identical to the reset values, applied asynchronously.
- Throughput:
  - Input: 1 element/cycle in FILL.
  - Output: 1 element/cycle in EMIT.
  - Fill and emit do not overlap.

Decomposition:
- Shared package: state encodings (IDLE, FILL, EMIT, DRAIN, NEXT, DONE) and the pool_type constants shared with pooling_unit.
- One sub-module, pool_line_buffer:
  - MAX_POOL_SIZE×MAX_WIDTH storage.
  - One write port (row, col, data, we) and one asynchronous read port (row, col).
  - Must map to distributed RAM.

Test Plan:
- 1 channel, 4×4 input, K=2, S=2, in_data=0..15.
  - Output 0,1,4,5 | 2,3,6,7 | 8,9,12,13 | 10,11,14,15.
  - out_win_last on 5, 7, 13, 15; out_plane_last on 15; done pulses once.
- 1 channel, 4×4 input, K=3, S=1, data 0..15.
  - Windows {0,1,2,4,5,6,8,9,10}, {1,2,3,5,6,7,9,10,11}, {4,...,14}, {5,...,15}.
  - Only one new row is fetched between output rows.
- 2 channels, 5×5 input, K=2, S=2, data 0..49.
  - Channel 0 windows start at 0, 2, 10, 12; channel 1 windows start at 25, 27, 35, 37.
  - Column 4 and row 4 are never emitted; 50 inputs are consumed.
- Backpressure on case 1, with out_ready toggling 1-0-0-1 randomly.
  - Output sequence is identical; out_data is stable during stalls; no element is lost or duplicated.
- Illegal config: K=4 with MAX_POOL_SIZE=3, or S=3 with K=2.
  - cfg_err=1, done pulses, in_ready never asserts.
  - A following legal start clears cfg_err.
- Clear asserted mid-EMIT in case 1.
  - Next cycle: out_valid=0, busy=0, no done pulse.
  - A restart with the same data reproduces the full case 1 output.
